// File: rtl/pd0_pkg.sv
// PD0 warm-up shared definitions.
// Reset value and the AND helper used by all three datapaths.
package pd0_pkg;

  localparam logic CLR_VAL = 1'b0;

  function automatic logic and2(
    input logic a,
    input logic b
  );
    return a & b;
  endfunction

endpackage

// File: rtl/pd0.sv
// PD0 core: combinational, async-clear registered and
// two-stage registered AND datapaths, driven via probes.
module pd0
  import pd0_pkg::*;
(
  input logic clock,
  input logic reset
);

  logic assign_and_x;
  logic assign_and_y;
  logic assign_and_z;

  logic ex33_areset;
  logic ex33_x;
  logic ex33_y;
  logic ex33_z;

  logic ex34_x;
  logic ex34_y;
  logic ex34_z;
  logic xr;
  logic yr;

  // pure combinational AND, ignores reset
  always_comb begin
    assign_and_z = and2(assign_and_x, assign_and_y);
  end

  // registered AND, async clear wins over clock
  always_ff @(posedge clock or posedge ex33_areset) begin
    if (ex33_areset) begin
      ex33_z <= CLR_VAL;
    end else if (reset) begin
      ex33_z <= CLR_VAL;
    end else begin
      ex33_z <= and2(ex33_x, ex33_y);
    end
  end

  // two-stage AND: capture inputs, then combine
  always_ff @(posedge clock) begin
    if (reset) begin
      xr     <= CLR_VAL;
      yr     <= CLR_VAL;
      ex34_z <= CLR_VAL;
    end else begin
      xr     <= ex34_x;
      yr     <= ex34_y;
      ex34_z <= and2(xr, yr);
    end
  end

endmodule

// File: rtl/pd0_design_wrapper.sv
// PD0 top-level wrapper.
// Holds the single core instance reached by probes.
module pd0_design_wrapper (
  input logic clock,
  input logic reset
);

  pd0 core (
    .clock (clock),
    .reset (reset)
  );

endmodule

// File: tb/tb_pd0_design_wrapper.sv
// PD0 wrapper bench: clock/reset generator plus
// directed probe stimulus with hand-computed results.
`ifndef PD0_SIGNALS_H
`define PD0_SIGNALS_H
`define ASSIGN_AND_X dut.core.assign_and_x
`define ASSIGN_AND_Y dut.core.assign_and_y
`define ASSIGN_AND_Z dut.core.assign_and_z
`define PROBE_EX33_ARESET dut.core.ex33_areset
`define PROBE_EX33_X dut.core.ex33_x
`define PROBE_EX33_Y dut.core.ex33_y
`define PROBE_EX33_Z dut.core.ex33_z
`define PROBE_EX34_X dut.core.ex34_x
`define PROBE_EX34_Y dut.core.ex34_y
`define PROBE_EX34_Z dut.core.ex34_z
`endif

module clockgen #(
  parameter int CLK_HALF_PERIOD = 5,
  parameter int RST_CYCLES      = 5
) (
  output logic clk,
  output logic rst
);

  int edges = 0;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    forever #(CLK_HALF_PERIOD) clk = ~clk;
  end

  // drop rst after the configured number of edges
  always @(posedge clk) begin
    edges <= edges + 1;
    if (edges + 1 >= RST_CYCLES) rst <= 1'b0;
  end

endmodule

module tb_pd0_design_wrapper;

  logic clk;
  logic rst;
  logic tb_rst;
  logic reset;

  int n_chk  = 0;
  int n_fail = 0;

  time t_p1;
  time t_p2;

  assign reset = rst | tb_rst;

  clockgen #(
    .CLK_HALF_PERIOD (5),
    .RST_CYCLES      (5)
  ) u_clkgen (
    .clk (clk),
    .rst (rst)
  );

  pd0_design_wrapper dut (
    .clock (clk),
    .reset (reset)
  );

  task automatic check(
    input string tag,
    input logic  obs,
    input logic  exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b",
               tag, obs, exp);
    end
  endtask

  initial begin
    @(posedge clk);
    t_p1 = $time;
    @(posedge clk);
    t_p2 = $time;
  end

  initial begin
    logic [1:0] v;
    logic       e;

    tb_rst = 1'b0;
    `ASSIGN_AND_X      = 1'b0;
    `ASSIGN_AND_Y      = 1'b0;
    `PROBE_EX33_ARESET = 1'b0;
    `PROBE_EX33_X      = 1'b1;
    `PROBE_EX33_Y      = 1'b1;
    `PROBE_EX34_X      = 1'b1;
    `PROBE_EX34_Y      = 1'b1;

    // edges 1..5 are under reset
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("rst_ex33_z_%0d", i),
            `PROBE_EX33_Z, 1'b0);
      check($sformatf("rst_ex34_z_%0d", i),
            `PROBE_EX34_Z, 1'b0);
      check($sformatf("rst_xr_%0d", i),
            dut.core.xr, 1'b0);
      check($sformatf("rst_yr_%0d", i),
            dut.core.yr, 1'b0);
      if (i == 4) check("rst_high_e4", rst, 1'b1);
      if (i == 5) check("rst_low_e5", rst, 1'b0);
    end

    check("clk_period", (t_p2 - t_p1) == 10, 1'b1);

    `ASSIGN_AND_X = 1'b1;
    `ASSIGN_AND_Y = 1'b1;
    #1;
    check("and_during_rst", `ASSIGN_AND_Z, 1'b1);

    // edge 6: first edge out of reset
    @(negedge clk);
    check("ex33_set_e6", `PROBE_EX33_Z, 1'b1);
    check("ex34_lat_e6", `PROBE_EX34_Z, 1'b0);
    // edge 7
    @(negedge clk);
    check("ex34_rise_e7", `PROBE_EX34_Z, 1'b1);
    `PROBE_EX34_Y = 1'b0;
    `PROBE_EX33_Y = 1'b0;
    // edge 8
    @(negedge clk);
    check("ex33_fall_e8", `PROBE_EX33_Z, 1'b0);
    check("ex34_hold_e8", `PROBE_EX34_Z, 1'b1);
    `PROBE_EX33_Y = 1'b1;
    // edge 9
    @(negedge clk);
    check("ex34_fall_e9", `PROBE_EX34_Z, 1'b0);
    check("ex33_back_e9", `PROBE_EX33_Z, 1'b1);

    // async clear pulse from negedge
    `PROBE_EX33_ARESET = 1'b1;
    #1;
    check("areset_imm", `PROBE_EX33_Z, 1'b0);
    #3;
    check("areset_hold", `PROBE_EX33_Z, 1'b0);
    @(posedge clk);
    #1;
    `PROBE_EX33_ARESET = 1'b0;
    @(negedge clk);
    check("areset_edge", `PROBE_EX33_Z, 1'b0);
    @(negedge clk);
    check("areset_reload", `PROBE_EX33_Z, 1'b1);

    // mid-run synchronous reset
    `PROBE_EX34_Y = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ex34_pre_rst", `PROBE_EX34_Z, 1'b1);
    tb_rst = 1'b1;
    @(negedge clk);
    check("srst_ex33", `PROBE_EX33_Z, 1'b0);
    check("srst_ex34", `PROBE_EX34_Z, 1'b0);
    check("srst_xr", dut.core.xr, 1'b0);
    tb_rst = 1'b0;
    @(negedge clk);
    check("srst_rel_ex34", `PROBE_EX34_Z, 1'b0);
    check("srst_rel_ex33", `PROBE_EX33_Z, 1'b1);
    @(negedge clk);
    check("srst_rise_ex34", `PROBE_EX34_Z, 1'b1);

    // combinational AND from counter bits
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      v = i[1:0];
      `ASSIGN_AND_X = v[0];
      `ASSIGN_AND_Y = v[1];
      e = (v == 2'b11);
      #1;
      check($sformatf("and_%0d", i),
            `ASSIGN_AND_Z, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pd0_design_wrapper.md
# pd0_design_wrapper

Top-level wrapper for the PD0 warm-up exercises, with a free-running clock/reset generator (`clockgen`) for the bench. The wrapper instantiates one core, instance name `core`, which holds three small AND datapaths:

- a combinational AND;
- a registered AND with asynchronous clear;
- a two-stage registered AND.

The core has no functional ports. It is stimulated and observed through named internal signals reached hierarchically at `dut.core.<signal>`.

## Interface
Parameters:
- `CLK_HALF_PERIOD`, default 5: `clockgen` half period in time units.
- `RST_CYCLES`, default 5: number of rising clock edges for which `clockgen` holds `rst` high at start-up.

design_wrapper ports:
- `clock`  input  1  system clock.
- `reset`  input  1  reset, synchronous, active-high; clock `clock`.

clockgen ports:
- `clk`  output  1  clock, starts at 0, toggles every `CLK_HALF_PERIOD`.
- `rst`  output  1  high from time 0; goes low after `RST_CYCLES` rising edges of `clk`.

Core internal probe signals:
- All are 1 bit.
- Inputs are declared as plain variables with no internal driver, so the bench can assign them hierarchically.
- Names are exported as macros in `signals.h`.

| Macro | Core signal | Role |
|---|---|---|
| `ASSIGN_AND_X` | `assign_and_x` | input |
| `ASSIGN_AND_Y` | `assign_and_y` | input |
| `ASSIGN_AND_Z` | `assign_and_z` | output |
| `PROBE_EX33_ARESET` | `ex33_areset` | input |
| `PROBE_EX33_X` | `ex33_x` | input |
| `PROBE_EX33_Y` | `ex33_y` | input |
| `PROBE_EX33_Z` | `ex33_z` | output |
| `PROBE_EX34_X` | `ex34_x` | input |
| `PROBE_EX34_Y` | `ex34_y` | input |
| `PROBE_EX34_Z` | `ex34_z` | output |

## Operation
- **assign_and**
  - `assign_and_z = assign_and_x & assign_and_y`, purely combinational.
  - No state, not affected by `reset`.
- **ex33 (registered AND, asynchronous clear)**
  - One flop sensitive to posedge `clock` or posedge `ex33_areset`.
  - While `ex33_areset` = 1: `ex33_z` = 0 immediately, independent of the clock.
  - Otherwise, on each rising `clock`: `ex33_z <= ex33_x & ex33_y`.
  - `reset` also clears `ex33_z` to 0 synchronously.
- **ex34 (two-stage registered AND)**
  - Stage 1 on each rising `clock`: `xr <= ex34_x`, `yr <= ex34_y`.
  - Stage 2 on each rising `clock`: `ex34_z <= xr & yr`.
  - `reset` synchronously clears `xr`, `yr` and `ex34_z` to 0.
- Outputs must never be X once reset has completed.

## Timing
- `assign_and_z`: zero cycles of latency.
- `ex33_z`:
  - One cycle of latency.
  - The value after edge N equals `x & y` sampled at edge N.
  - An `ex33_areset` pulse, asserted at the negedge and released at the next posedge, forces `ex33_z` = 0 during the pulse.
  - The flop reloads from x/y only at the first posedge that sees areset low.
- `ex34_z`: two cycles of latency. The value after edge N+1 equals `x & y` sampled at edge N.
- Reset values of all three outputs: 0. `assign_and_z` follows its inputs regardless of reset.

## Structure
- No shared package is needed.
- `signals.h` holds only the probe-path macros.
- `clockgen` is a separate, non-synthesizable module.
- The core is a separate module, `pd0`, instantiated as `core` inside `design_wrapper`.

## Test plan
- `assign_and_x` and `assign_and_y` driven from counter bits 0 and 1, checked over 100 cycles: `assign_and_z` = x&y every cycle, with no X values.
- ex33 with x=1, y=1, areset=0 at edge N: `ex33_z` = 1 after edge N. With x=1, y=0: `ex33_z` = 0 after the next edge.
- ex33 with x=y=1 and areset pulsed high at a negedge: `ex33_z` drops to 0 before the next posedge. After release, it returns to 1 at the next edge.
- ex34 with x=y=1 held from edge N: `ex34_z` = 0 after edge N and 1 after edge N+1. Toggling y to 0 makes z fall two edges later.
- `reset` held for 5 edges with all inputs at 1: `ex33_z`, `ex34_z`, `xr` and `yr` all read 0 during reset. `ex34_z` rises two edges after reset is released.
- `clockgen`: `clk` period is 10 time units, and `rst` is low after the 5th rising edge.
